// File: rtl/qsys_mpu_pkg.sv
// Shared register map, CTRL bit positions and FSM encoding for the MPU FSYNC strobe port.
package qsys_mpu_pkg;

    localparam logic [2:0] REG_LEVEL  = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_WIDTH  = 3'd2;
    localparam logic [2:0] REG_PERIOD = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_POL      = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_BUSY     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } fsync_state_t;

endpackage

// File: rtl/mpu_fsync_timer.sv
// Loadable down-counter; expire flags the last cycle of a phase that was loaded with its length.
module mpu_fsync_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // Holds at zero when idle so a stale count never fires expire.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/qsys_mpu_fsync.sv
// Avalon-MM FSYNC/trigger strobe generator: one-shot or periodic pulses with done/irq.
// Periodic mode (PERIODIC bit, PERIOD register, GAP state) is built only with MPU_FSYNC_PERIODIC_EN.
module qsys_mpu_fsync
    import qsys_mpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        irq
);

    fsync_state_t     state;
    fsync_state_t     state_next;
    logic             pol;
    logic             pol_next;
    logic             irq_en;
    logic             done;
    logic             start_pend;
    logic             periodic;
    logic [CNT_W-1:0] width_reg;
    logic [CNT_W-1:0] w_eff;
    logic             wr;
    logic             wr_ctrl;
    logic             start_req;
    logic             set_done;
    logic             busy;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expire;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == REG_CTRL);
    assign busy      = (state != ST_IDLE);
    assign w_eff     = (width_reg == '0) ? CNT_W'(1) : width_reg;
    assign pol_next  = wr_ctrl ? writedata[CTRL_POL] : pol;
    assign irq       = done & irq_en;
    assign unused_wdata = ^writedata;

    // The accepting edge only arms start_pend; PULSE begins on the following edge so that
    // out_port, the state and the timer load all change together.
    assign start_req = wr_ctrl && writedata[CTRL_START] && (state == ST_IDLE) && !start_pend;

`ifdef MPU_FSYNC_PERIODIC_EN
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] w_work;
    logic [CNT_W-1:0] p_work;
    logic [CNT_W-1:0] gap_len;

    assign gap_len = (p_work > w_work) ? (p_work - w_work) : CNT_W'(1);

    // Working copies are refreshed on every entry to PULSE, so register writes only affect the next pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            periodic   <= 1'b0;
            period_reg <= '0;
            w_work     <= CNT_W'(1);
            p_work     <= '0;
        end else begin
            if (wr_ctrl) begin
                periodic <= writedata[CTRL_PERIODIC];
            end
            if (wr && (address == REG_PERIOD)) begin
                period_reg <= writedata[CNT_W-1:0];
            end
            if ((state_next == ST_PULSE) && (state != ST_PULSE)) begin
                w_work <= w_eff;
                p_work <= period_reg;
            end
        end
    end
`else
    assign periodic = 1'b0;
`endif

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_value  = w_eff;
        set_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_pend) begin
                    state_next = ST_PULSE;
                    tmr_load   = 1'b1;
                    tmr_value  = w_eff;
                end
            end
            ST_PULSE: begin
                if (tmr_expire) begin
                    set_done   = 1'b1;
                    state_next = ST_IDLE;
`ifdef MPU_FSYNC_PERIODIC_EN
                    if (periodic) begin
                        state_next = ST_GAP;
                        tmr_load   = 1'b1;
                        tmr_value  = gap_len;
                    end
`endif
                end
            end
`ifdef MPU_FSYNC_PERIODIC_EN
            ST_GAP: begin
                if (!periodic) begin
                    state_next = ST_IDLE;
                end else if (tmr_expire) begin
                    state_next = ST_PULSE;
                    tmr_load   = 1'b1;
                    tmr_value  = w_eff;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            REG_LEVEL:  rd_mux[0] = out_port;
            REG_CTRL: begin
                rd_mux[CTRL_PERIODIC] = periodic;
                rd_mux[CTRL_POL]      = pol;
                rd_mux[CTRL_IRQ_EN]   = irq_en;
                rd_mux[CTRL_BUSY]     = busy;
            end
            REG_WIDTH:  rd_mux = 32'(width_reg);
`ifdef MPU_FSYNC_PERIODIC_EN
            REG_PERIOD: rd_mux = 32'(period_reg);
`endif
            REG_STATUS: rd_mux[0] = done;
            default:    rd_mux = 32'd0;
        endcase
    end

    // DONE set beats a same-cycle STATUS clear; POL acts on out_port at its write edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            start_pend <= 1'b0;
            pol        <= 1'b1;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            width_reg  <= CNT_W'(1);
            out_port   <= 1'b0;
            readdata   <= 32'd0;
        end else begin
            state      <= state_next;
            start_pend <= start_req;
            out_port   <= (state_next == ST_PULSE) ? pol_next : !pol_next;
            readdata   <= rd_mux;
            if (wr_ctrl) begin
                pol    <= writedata[CTRL_POL];
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (wr && (address == REG_WIDTH)) begin
                width_reg <= writedata[CNT_W-1:0];
            end
            if (set_done) begin
                done <= 1'b1;
            end else if (wr && (address == REG_STATUS)) begin
                done <= 1'b0;
            end
        end
    end

    mpu_fsync_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

endmodule

// File: tb/tb_qsys_mpu_fsync.sv
// Bench for qsys_mpu_fsync: bus driver tasks, pulse monitor with expected-width queue, read scoreboard.
module tb_qsys_mpu_fsync;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
    logic        irq;

`ifdef MPU_FSYNC_PERIODIC_EN
    localparam int          N_PER      = 6;
    localparam int          N_DEG      = 3;
    localparam logic [31:0] EXP_PERIOD = 32'd10;
`else
    localparam int          N_PER      = 1;
    localparam int          N_DEG      = 1;
    localparam logic [31:0] EXP_PERIOD = 32'd0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_rises = 0;
    int          run = 0;
    bit          prev_act = 0;
    bit          act;
    bit          mon_en = 1;
    logic        cur_pol = 1'b1;
    logic [31:0] exp_q[$];
    logic [31:0] rd_q[$];
    int          rise_q[$];
    int          base;

    qsys_mpu_fsync dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        @(posedge clk);
        #1;
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        data       = readdata;
        chipselect = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        rd_q.push_back(exp);
        bus_read(addr, got);
        check(tag, got, rd_q.pop_front());
    endtask

    task automatic wait_q_empty(input string tag, input int max_cyc);
        for (int g = 0; g < max_cyc && exp_q.size() != 0; g++) begin
            @(negedge clk);
            #1;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_rises(input int target, input int max_cyc);
        for (int g = 0; g < max_cyc && n_rises < target; g++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Pulse monitor: measures each active run of out_port and scores it against exp_q.
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            run      = 0;
            prev_act = 0;
        end else begin
            act = (out_port == cur_pol);
            if (act && !prev_act) begin
                rise_q.push_back(cyc);
                n_rises++;
            end
            if (act) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) check("pulse_extra", run, 0);
                else check("pulse_w", run, exp_q.pop_front());
                run = 0;
            end
            prev_act = act;
        end
    end

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out", out_port, 0);
        check("rst_irq", irq, 0);
        check("rst_rd", readdata, 0);
        rd_check("rst_level", 3'd0, 32'h0);
        rd_check("rst_ctrl", 3'd1, 32'h4);
        rd_check("rst_width", 3'd2, 32'h1);
        rd_check("rst_period", 3'd3, 32'h0);
        rd_check("rst_status", 3'd4, 32'h0);

        // one-shot pulse with interrupt, cycle-exact
        bus_write(3'd2, 32'd5);
        exp_q.push_back(32'd5);
        bus_write(3'd1, 32'h0D);
        @(negedge clk);
        check("os_lat", out_port, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("os_act", out_port, 1);
            check("os_irq_lo", irq, 0);
        end
        @(negedge clk);
        check("os_fall", out_port, 0);
        check("os_irq_hi", irq, 1);
        wait_q_empty("os_tmo", 20);
        rd_check("os_status", 3'd4, 32'h1);
        rd_check("os_ctrl", 3'd1, 32'h0C);
        bus_write(3'd4, 32'd0);
        @(negedge clk);
        check("os_irq_clr", irq, 0);

        // periodic mode, stopped mid-pulse
        bus_write(3'd2, 32'd3);
        bus_write(3'd3, 32'd10);
        rd_check("per_period", 3'd3, EXP_PERIOD);
        for (int i = 0; i < N_PER; i++) exp_q.push_back(32'd3);
        base = n_rises;
        bus_write(3'd1, 32'h07);
        wait_rises(base + N_PER, 300);
        bus_write(3'd1, 32'h04);
        wait_q_empty("per_tmo", 50);
        repeat (15) @(negedge clk);
        check("per_rises", n_rises - base, N_PER);
        rd_check("per_ctrl_idle", 3'd1, 32'h04);
`ifdef MPU_FSYNC_PERIODIC_EN
        for (int i = 1; i < 6; i++) check("per_gap", rise_q[base + i] - rise_q[base + i - 1], 10);
`endif

        // degenerate values
        bus_write(3'd2, 32'd0);
        rd_check("deg_width0", 3'd2, 32'h0);
        exp_q.push_back(32'd1);
        bus_write(3'd1, 32'h05);
        wait_q_empty("deg0_tmo", 30);
        bus_write(3'd2, 32'd4);
        bus_write(3'd3, 32'd2);
        for (int i = 0; i < N_DEG; i++) exp_q.push_back(32'd4);
        base = n_rises;
        bus_write(3'd1, 32'h07);
        wait_rises(base + N_DEG, 200);
        bus_write(3'd1, 32'h04);
        wait_q_empty("deg_tmo", 50);
        repeat (10) @(negedge clk);
        check("deg_rises", n_rises - base, N_DEG);
`ifdef MPU_FSYNC_PERIODIC_EN
        for (int i = 1; i < 3; i++) check("deg_gap", rise_q[base + i] - rise_q[base + i - 1], 5);
`endif

        // START while busy is ignored
        bus_write(3'd2, 32'd6);
        exp_q.push_back(32'd6);
        base = n_rises;
        bus_write(3'd1, 32'h05);
        bus_write(3'd1, 32'h05);
        wait_q_empty("busy_tmo", 40);
        repeat (10) @(negedge clk);
        check("busy_rises", n_rises - base, 1);

        // STATUS write on the DONE-set edge: set wins
        bus_write(3'd4, 32'd0);
        rd_check("conf_status0", 3'd4, 32'h0);
        bus_write(3'd2, 32'd2);
        exp_q.push_back(32'd2);
        bus_write(3'd1, 32'h0D);
        @(posedge clk);
        bus_write(3'd4, 32'd0);
        @(negedge clk);
        check("conf_irq", irq, 1);
        rd_check("conf_status1", 3'd4, 32'h1);
        wait_q_empty("conf_tmo", 20);
        bus_write(3'd4, 32'd0);

        // reset during the 2nd cycle of an 8-cycle active-low pulse
        bus_write(3'd2, 32'd8);
        mon_en = 1'b0;
        bus_write(3'd1, 32'h09);
        @(negedge clk);
        check("rst_mid_idle", out_port, 1);
        @(negedge clk);
        check("rst_mid_act", out_port, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_out", out_port, 0);
        check("rst_mid_irq", irq, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_mid_quiet", {30'd0, out_port, irq}, 0);
        end
        rd_check("rst_mid_ctrl", 3'd1, 32'h4);
        rd_check("rst_mid_status", 3'd4, 32'h0);

        check("exp_q_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
